// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: data modes, FSM states and
// access-size helpers.
package lsu_pkg;

  localparam logic [2:0] DM_B  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_W  = 3'd2;
  localparam logic [2:0] DM_BU = 3'd4;
  localparam logic [2:0] DM_HU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_FIN} state_e;

  // Modes 3/6/7 fall through to word size.
  function automatic logic [2:0] dm_size(input logic [2:0] dm);
    case (dm[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] dm_mask(input logic [2:0] dm);
    case (dm[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_split(input logic [2:0] dm, input logic [1:0] off);
    logic [2:0] last;
    last = {1'b0, off} + dm_size(dm);
    return last > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_mem_seq_if.sv
// Request/response handshake plus word-memory bus of the sequencer.
interface lsu_mem_seq_if;
  import lsu_pkg::*;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_datamode_i;
  logic [13:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_datamode_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_datamode_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte mask / data shift for stores,
// merge / extract / extend for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  dm_i,
  input  logic [1:0]  off_i,
  input  logic        split_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wd0_o,
  output logic [31:0] wd1_o,
  output logic [31:0] ld_o
);

  logic [4:0]  sh;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic [63:0] r64;

  assign sh  = {off_i, 3'b000};
  assign m8  = {4'b0000, dm_mask(dm_i)} << off_i;
  assign d64 = {32'b0, wdata_i} << sh;
  // Split loads have the first word parked in word0; the second arrives now.
  assign r64 = (split_i ? {rdata_i, word0_i} : {32'b0, rdata_i}) >> sh;

  assign be0_o = m8[3:0];
  assign be1_o = m8[7:4];
  assign wd0_o = d64[31:0];
  assign wd1_o = d64[63:32];

  always_comb begin
    ld_o = r64[31:0];
    case (dm_i)
      DM_B:    ld_o = {{24{r64[7]}}, r64[7:0]};
      DM_H:    ld_o = {{16{r64[15]}}, r64[15:0]};
      DM_BU:   ld_o = {24'b0, r64[7:0]};
      DM_HU:   ld_o = {16'b0, r64[15:0]};
      default: ld_o = r64[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_mem_seq.sv
// Load/store sequencer: one access at a time, word-crossing accesses split
// into two memory beats, one response per request.
module lsu_mem_seq
  import lsu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  lsu_mem_seq_if.slave  bus
);

  state_e      state_q;
  logic        we_q;
  logic [2:0]  dm_q;
  logic [13:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word0_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;

  logic        split;
  logic [11:0] w0, w1;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1, ld;
  logic        beat0, beat1, mem_en;

  assign split = is_split(dm_q, addr_q[1:0]);
  assign w0    = addr_q[13:2];
  assign w1    = w0 + 12'd1;

  lsu_align u_align (
    .dm_i    (dm_q),
    .off_i   (addr_q[1:0]),
    .split_i (split),
    .wdata_i (wdata_q),
    .word0_i (word0_q),
    .rdata_i (bus.mem_rdata_i),
    .be0_o   (be0),
    .be1_o   (be1),
    .wd0_o   (wd0),
    .wd1_o   (wd1),
    .ld_o    (ld)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      dm_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word0_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.req_valid_i) begin
          we_q    <= bus.req_we_i;
          dm_q    <= bus.req_datamode_i;
          addr_q  <= bus.req_addr_i;
          wdata_q <= bus.req_wdata_i;
          state_q <= S_BEAT0;
        end
        S_BEAT0: begin
          if (split) begin
            state_q <= S_BEAT1;
          end else if (we_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            state_q <= S_FIN;
          end
        end
        S_BEAT1: begin
          if (we_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            word0_q <= bus.mem_rdata_i;
            state_q <= S_FIN;
          end
        end
        default: begin
          rdata_q      <= ld;
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Gating with rst_ni drops a beat already in flight when reset arrives.
  assign beat0  = (state_q == S_BEAT0) && rst_ni;
  assign beat1  = (state_q == S_BEAT1) && rst_ni;
  assign mem_en = beat0 || beat1;

  assign bus.req_ready_o  = (state_q == S_IDLE) && rst_ni;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.mem_en_o     = mem_en;
  assign bus.mem_we_o     = mem_en && we_q;
  assign bus.mem_be_o     = beat0 ? be0 : (beat1 ? be1 : 4'b0000);
  assign bus.mem_addr_o   = beat0 ? w0  : (beat1 ? w1  : 12'h000);
  assign bus.mem_wdata_o  = (beat0 && we_q) ? wd0 : ((beat1 && we_q) ? wd1 : 32'h0);

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Directed bench for lsu_mem_seq: word-memory model, beat capture and
// hand-computed expectations.
module tb_lsu_mem_seq;
  import lsu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  lsu_mem_seq_if bus();

  lsu_mem_seq dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Word memory model with a preload port, one-cycle read latency.
  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (bus.mem_en_o && !bus.mem_we_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    if (bus.mem_en_o && bus.mem_we_o)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be_o[i]) mem[bus.mem_addr_o][8*i +: 8] <= bus.mem_wdata_o[8*i +: 8];
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  logic [11:0] ba  [4];
  logic [3:0]  bb  [4];
  logic [31:0] bw  [4];
  logic        bwe [4];
  int          nb, rc;
  logic [31:0] rd;

  // Presents a request, then records every beat until the response.
  // With now=1 the request is driven at the current negedge.
  task automatic run(input logic now, input logic we, input logic [2:0] dm,
                     input logic [13:0] addr, input logic [31:0] wdata);
    int cyc;
    if (!now) @(negedge clk_i);
    chk("ready_at_req", {31'b0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_datamode_i = dm;
    bus.req_addr_i = addr; bus.req_wdata_i = wdata;
    nb = 0; rc = 0; rd = '0; cyc = 0;
    while (rc == 0 && cyc < 12) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      if (bus.mem_en_o && nb < 4) begin
        ba[nb] = bus.mem_addr_o; bb[nb] = bus.mem_be_o;
        bw[nb] = bus.mem_wdata_o; bwe[nb] = bus.mem_we_o;
        nb++;
      end
      if (bus.resp_valid_o) begin
        rc = cyc; rd = bus.resp_rdata_o;
      end
    end
    if (rc == 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_datamode_i = '0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("rst_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_en_o}, 32'd0);
    chk("rst_mem_be", {28'b0, bus.mem_be_o}, 32'd0);
    rst_ni = 1'b1;

    // Aligned LW
    preload(12'h004, 32'hDEADBEEF);
    run(1'b0, 1'b0, DM_W, 14'h0010, 32'h0);
    chk("lw_beats", nb, 32'd1);
    chk("lw_addr", {20'b0, ba[0]}, 32'h004);
    chk("lw_be", {28'b0, bb[0]}, 32'hF);
    chk("lw_we", {31'b0, bwe[0]}, 32'd0);
    chk("lw_cyc", rc, 32'd3);
    chk("lw_data", rd, 32'hDEADBEEF);

    // Byte loads, signed/unsigned, top lane
    preload(12'h004, 32'hAABBCCDD);
    preload(12'h005, 32'h11223344);
    run(1'b0, 1'b0, DM_B, 14'h0013, 32'h0);
    chk("lb_data", rd, 32'hFFFFFFAA);
    chk("lb_cyc", rc, 32'd3);
    run(1'b0, 1'b0, DM_BU, 14'h0013, 32'h0);
    chk("lbu_data", rd, 32'h000000AA);

    // Split LH
    run(1'b0, 1'b0, DM_H, 14'h0013, 32'h0);
    chk("lh_beats", nb, 32'd2);
    chk("lh_addr0", {20'b0, ba[0]}, 32'h004);
    chk("lh_addr1", {20'b0, ba[1]}, 32'h005);
    chk("lh_cyc", rc, 32'd4);
    chk("lh_data", rd, 32'h000044AA);

    // Aligned LH with sign bit set, LHU of same
    preload(12'h009, 32'h00008001);
    run(1'b0, 1'b0, DM_H, 14'h0024, 32'h0);
    chk("lh_sign", rd, 32'hFFFF8001);
    run(1'b0, 1'b0, DM_HU, 14'h0024, 32'h0);
    chk("lhu_zero", rd, 32'h00008001);

    // Split SW, then read back across the boundary
    preload(12'h000, 32'h0);
    preload(12'h001, 32'h0);
    run(1'b0, 1'b1, DM_W, 14'h0002, 32'h12345678);
    chk("sw_beats", nb, 32'd2);
    chk("sw_addr0", {20'b0, ba[0]}, 32'h000);
    chk("sw_be0", {28'b0, bb[0]}, 32'hC);
    chk("sw_wd0", bw[0], 32'h56780000);
    chk("sw_we0", {31'b0, bwe[0]}, 32'd1);
    chk("sw_addr1", {20'b0, ba[1]}, 32'h001);
    chk("sw_be1", {28'b0, bb[1]}, 32'h3);
    chk("sw_wd1", bw[1], 32'h00001234);
    chk("sw_cyc", rc, 32'd3);
    run(1'b0, 1'b0, DM_W, 14'h0002, 32'h0);
    chk("sw_readback", rd, 32'h12345678);
    chk("split_lw_cyc", rc, 32'd4);

    // Word-address wrap
    preload(12'hFFF, 32'hCAFEF00D);
    preload(12'h000, 32'h13572468);
    run(1'b0, 1'b0, DM_W, 14'h3FFE, 32'h0);
    chk("wrap_addr0", {20'b0, ba[0]}, 32'hFFF);
    chk("wrap_addr1", {20'b0, ba[1]}, 32'h000);
    chk("wrap_data", rd, 32'h2468CAFE);

    // Aligned SW with a LW presented in its response cycle
    run(1'b0, 1'b1, DM_W, 14'h0020, 32'h0BADF00D);
    chk("b2b_sw_cyc", rc, 32'd2);
    chk("b2b_sw_be", {28'b0, bb[0]}, 32'hF);
    run(1'b1, 1'b0, DM_W, 14'h0020, 32'h0);
    chk("b2b_lw_addr", {20'b0, ba[0]}, 32'h008);
    chk("b2b_lw_cyc", rc, 32'd3);
    chk("b2b_lw_data", rd, 32'h0BADF00D);

    // Reset during beat1 of a split store
    preload(12'h001, 32'h55555555);
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_datamode_i = DM_W;
    bus.req_addr_i = 14'h0002; bus.req_wdata_i = 32'hA1B2C3D4;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    chk("rst_mid_beat0", {31'b0, bus.mem_en_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_no_beat1", {31'b0, bus.mem_en_o}, 32'd0);
    chk("rst_mid_ready_low", {31'b0, bus.req_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_mid_no_resp", {31'b0, bus.resp_valid_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_rel_ready", {31'b0, bus.req_ready_o}, 32'd1);
    chk("rst_rel_no_resp", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("rst_mid_word1", mem[1], 32'h55555555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_seq.md
# lsu_mem_seq

Load/store sequencer that sits between the core's load-store stage and a word-wide synchronous data memory with byte enables. Accepts one byte, halfword or word access at a time on a 14-bit byte address and splits accesses that cross a word boundary into two memory beats. For loads it merges the read words, then sign- or zero-extends the result. It returns one response per request.

## Interface
- No parameters. Address width is 14 bits (byte) and 12 bits (word), fixed.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_datamode_i  in  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; 3/6/7 treated as word.
- req_addr_i  in  14  byte address; any alignment is legal.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle pulse per completed request.
- resp_rdata_o  out  32  load result, extended; held for stores.
- mem_en_o  out  1  memory access this cycle.
- mem_we_o  out  1  write.
- mem_be_o  out  4  byte enables; bit i = byte lane i.
- mem_addr_o  out  12  word address.
- mem_wdata_o  out  32  lane-aligned write data.
- mem_rdata_i  in  32  read data, valid the cycle after a read beat.

## Operation
- States: IDLE, BEAT0, BEAT1, FIN.
- req_ready_o = (state == IDLE) && rst_ni. On accept, latch we, datamode, addr and wdata, then go to BEAT0.
- size = 1/2/4 bytes from datamode[1:0] (0→1, 1→2, else 4). off = addr[1:0]. split = off + size > 4.
- Word addresses: w0 = addr[13:2]; w1 = w0 + 1 mod 4096, so 0xFFF wraps to 0x000.
- Byte mask m8 = ({4'b0, size mask} << off). Beat0 be = m8[3:0]; beat1 be = m8[7:4].
- Write data d64 = {32'b0, wdata} << (8·off). Beat0 wdata = d64[31:0]; beat1 wdata = d64[63:32].
- BEAT0: mem_en = 1, mem_addr = w0.
  - Store, not split: set resp_valid, go to IDLE.
  - Store, split: go to BEAT1.
  - Load, split: go to BEAT1.
  - Load, not split: go to FIN.
- BEAT1: mem_en = 1, mem_addr = w1.
  - Load: capture mem_rdata_i as word0, go to FIN.
  - Store: set resp_valid, go to IDLE.
- FIN (loads only):
  - Last word = mem_rdata_i.
  - r64 = {word1, word0} >> (8·off). Non-split loads use {0, mem_rdata_i}.
  - Extract size bytes. Sign-extend for modes 0/1, zero-extend for modes 4/5.
  - Register the result into resp_rdata_o, set resp_valid, go to IDLE.
- When mem_en_o = 0, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are all 0.
- The response pulse coincides with IDLE, so a new request may be accepted in the response cycle.

## Timing
- Accept in cycle 0.
- Aligned load: mem_en in cycle 1, resp in cycle 3.
- Split load: mem_en in cycles 1–2, resp in cycle 4.
- Aligned store: write in cycle 1, resp in cycle 2.
- Split store: writes in cycles 1–2, resp in cycle 3.
- All outputs are registered or decoded from state; no combinational path from req_* to mem_* or resp_*.
- Reset (rst_ni = 0 at a clock edge):
  - state = IDLE; resp_valid_o = 0; resp_rdata_o = 0; all mem_* = 0.
  - req_ready_o = 0 while rst_ni is low.
- Reset mid-operation: any pending beat is dropped and no response is issued. req_ready_o = 1 in the first cycle after release.

## Structure
- Package lsu_pkg holds:
  - datamode constants (DM_B, DM_H, DM_W, DM_BU, DM_HU);
  - the state enum;
  - a size-decode function.
- Sub-module lsu_align holds the combinational byte-mask/shift for stores and the extract/extend for loads. The FSM and all registers stay in lsu_mem_seq.

## Test plan
- LW at 0x0010, mem word 0x004 = 0xDEADBEEF -> exactly one read beat at addr 0x004 with be 1111; resp in cycle 3; rdata 0xDEADBEEF.
- LB / LBU at 0x0013 with word 0x004 = 0xAABBCCDD -> rdata 0xFFFFFFAA / 0x000000AA.
- LH at 0x0013 with word 0x004 = 0xAABBCCDD and word 0x005 = 0x11223344 -> beats at 0x004 then 0x005; resp in cycle 4; rdata 0x000044AA.
- SW 0x12345678 at 0x0002 -> beat0: addr 0x000, be 1100, wdata 0x56780000; beat1: addr 0x001, be 0011, wdata 0x00001234; resp in cycle 3.
- LW at 0x3FFE -> beats at 0xFFF then 0x000 (wrap); merged result correct.
- Reset driven low in cycle 2 of a split store -> no second beat, no resp; ready = 1 in the first cycle after release. Separately: a back-to-back request presented in a resp cycle is accepted in that same cycle.
